// File: rtl/delayfixed_seq_ctl.sv
// delayfixed_seq_ctl
// Shares one fixed-delay cell among NREQ requesters. Requests are served
// round-robin: the winner's launch raises the cell input, the synchronized
// cell output ends the FIRE phase, its fall ends the RELEASE phase, and a
// RECOVER gap is enforced before the next launch. Both active phases are
// bounded by TOUT_CYC cycles.
//
// Ports:
//   CELCLK    clock
//   CELRSTN   asynchronous active-low reset
//   req       level requests, one bit per requester
//   grant     one-hot owner of the delay cell
//   dly_i     drive to the delay-cell input
//   dly_o     delay-cell output, asynchronous to CELCLK
//   done      one-cycle completion pulse
//   done_id   index of the requester that completed, valid with done
//   tmo       one-cycle timeout pulse, coincident with done
//   busy      high whenever the sequencer is not idle
//   meas_cyc  launch-to-edge cycle count, valid with done
//
// Build option: define DELAYFIXED_SEQ_MEAS_EN to build the 8-bit launch-to-edge
// measurement. Without it meas_cyc is tied to 0 and the cycle counter is only
// as wide as the larger of TOUT_CYC and RECOV_CYC requires.
module delayfixed_seq_ctl #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned TOUT_CYC  = 16,
  parameter int unsigned RECOV_CYC = 4
) (
  input  logic            CELCLK,
  input  logic            CELRSTN,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            dly_i,
  input  logic            dly_o,
  output logic            done,
  output logic [2:0]      done_id,
  output logic            tmo,
  output logic            busy,
  output logic [7:0]      meas_cyc
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef DELAYFIXED_SEQ_MEAS_EN
  localparam int unsigned CNT_W = 8;
`else
  localparam int unsigned MAX_CYC = (TOUT_CYC > RECOV_CYC) ? TOUT_CYC : RECOV_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC);
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FIRE    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        ptr, ptr_nxt;
  logic [2:0]        owner, owner_nxt;
  logic [NREQ-1:0]   grant_nxt;
  logic              dly_i_nxt;
  logic              done_nxt;
  logic [2:0]        done_id_nxt;
  logic              tmo_nxt;
  logic              tmo_flag, tmo_flag_nxt;
  logic              busy_nxt;
  logic [1:0]        sync_q;
  logic              o_s;
  logic              pick_vld;
  logic [2:0]        pick_idx;
  int unsigned       cand;
`ifdef DELAYFIXED_SEQ_MEAS_EN
  logic [7:0]        meas_q, meas_nxt;
`endif

  // Two-flop synchronizer for the asynchronous cell output
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], dly_o};
    end
  end

  assign o_s = sync_q[1];

  // Round-robin pick: first set request at or after ptr, wrapping at NREQ-1
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 3'd0;
    cand     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!pick_vld && req[cand[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = 3'(cand);
      end
    end
  end

  // State and output registers
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ptr      <= 3'd0;
      owner    <= 3'd0;
      grant    <= '0;
      dly_i    <= 1'b0;
      done     <= 1'b0;
      done_id  <= 3'd0;
      tmo      <= 1'b0;
      tmo_flag <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      grant    <= grant_nxt;
      dly_i    <= dly_i_nxt;
      done     <= done_nxt;
      done_id  <= done_id_nxt;
      tmo      <= tmo_nxt;
      tmo_flag <= tmo_flag_nxt;
      busy     <= busy_nxt;
    end
  end

`ifdef DELAYFIXED_SEQ_MEAS_EN
  // Launch-to-edge measurement register
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      meas_q <= 8'h00;
    end else begin
      meas_q <= meas_nxt;
    end
  end

  assign meas_cyc = meas_q;
`else
  assign meas_cyc = 8'h00;
`endif

  // Next-state and output logic
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    ptr_nxt      = ptr;
    owner_nxt    = owner;
    grant_nxt    = grant;
    dly_i_nxt    = dly_i;
    done_nxt     = 1'b0;
    done_id_nxt  = done_id;
    tmo_nxt      = 1'b0;
    tmo_flag_nxt = tmo_flag;
`ifdef DELAYFIXED_SEQ_MEAS_EN
    meas_nxt     = meas_q;
`endif

    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          state_nxt    = ST_FIRE;
          cnt_nxt      = '0;
          owner_nxt    = pick_idx;
          ptr_nxt      = (pick_idx == 3'(NREQ - 1)) ? 3'd0 : pick_idx + 3'd1;
          grant_nxt    = NREQ'(1) << pick_idx;
          dly_i_nxt    = 1'b1;
          tmo_flag_nxt = 1'b0;
        end
      end

      ST_FIRE: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (o_s) begin
          state_nxt = ST_RELEASE;
          cnt_nxt   = '0;
          dly_i_nxt = 1'b0;
`ifdef DELAYFIXED_SEQ_MEAS_EN
          meas_nxt  = cnt;
`endif
        end else if (cnt == CNT_W'(TOUT_CYC - 1)) begin
          state_nxt    = ST_RELEASE;
          cnt_nxt      = '0;
          dly_i_nxt    = 1'b0;
          tmo_flag_nxt = 1'b1;
`ifdef DELAYFIXED_SEQ_MEAS_EN
          meas_nxt     = 8'hFF;
`endif
        end
      end

      ST_RELEASE: begin
        cnt_nxt = cnt + CNT_W'(1);
        // A cell output still high at the limit is a timeout on its own
        if (!o_s || (cnt == CNT_W'(TOUT_CYC - 1))) begin
          state_nxt   = ST_RECOVER;
          cnt_nxt     = '0;
          done_nxt    = 1'b1;
          done_id_nxt = owner;
          tmo_nxt     = tmo_flag | o_s;
          grant_nxt   = '0;
        end
      end

      ST_RECOVER: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(RECOV_CYC - 1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        grant_nxt = '0;
        dly_i_nxt = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_delayfixed_seq_ctl.sv
// Testbench for delayfixed_seq_ctl: table of single transactions against a
// behavioural delay cell, plus reset-mid-FIRE and continuous round-robin runs.
// Completions are checked by a scoreboard fed at each launch.
module tb_delayfixed_seq_ctl;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned TOUT_CYC  = 16;
  localparam int unsigned RECOV_CYC = 4;

  localparam int M_NORM  = 0;
  localparam int M_DEAD  = 1;
  localparam int M_STUCK = 2;

  logic            CELCLK = 1'b0;
  logic            CELRSTN;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic            dly_i;
  logic            dly_o;
  logic            done;
  logic [2:0]      done_id;
  logic            tmo;
  logic            busy;
  logic [7:0]      meas_cyc;

  delayfixed_seq_ctl #(
    .NREQ      (NREQ),
    .TOUT_CYC  (TOUT_CYC),
    .RECOV_CYC (RECOV_CYC)
  ) dut (
    .CELCLK   (CELCLK),
    .CELRSTN  (CELRSTN),
    .req      (req),
    .grant    (grant),
    .dly_i    (dly_i),
    .dly_o    (dly_o),
    .done     (done),
    .done_id  (done_id),
    .tmo      (tmo),
    .busy     (busy),
    .meas_cyc (meas_cyc)
  );

  always #5 CELCLK = ~CELCLK;

  // Behavioural delay cell: D-cycle delayed copy, dead, or stuck high after launch
  int         mode = M_NORM;
  int         dsel = 1;
  logic [7:0] pipe = 8'h00;
  logic       stuck_hi = 1'b0;

  always @(posedge CELCLK) begin
    pipe <= {pipe[6:0], dly_i};
    if (mode != M_STUCK) stuck_hi <= 1'b0;
    else if (dly_i) stuck_hi <= 1'b1;
  end

  assign dly_o = (mode == M_DEAD) ? 1'b0 :
                 (mode == M_STUCK) ? stuck_hi : pipe[3'(dsel - 1)];

  typedef struct {
    logic [3:0] req;
    int         mode;
    int         d;
    logic [3:0] grant;
    logic [2:0] id;
    logic       tmo;
    logic [7:0] meas;
    int         hi;
  } vec_t;

  typedef struct {
    logic [2:0] id;
    logic       tmo;
    logic [7:0] meas;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] em(input logic [7:0] m);
`ifdef DELAYFIXED_SEQ_MEAS_EN
    return m;
`else
    return (m == m) ? 8'h00 : 8'h00;
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [2:0] id, input logic t, input logic [7:0] m);
    exp_t e;
    e.id   = id;
    e.tmo  = t;
    e.meas = em(m);
    sb_q.push_back(e);
  endtask

  // Scoreboard: every done must match the oldest outstanding launch
  always @(negedge CELCLK) begin
    exp_t e;
    if (CELRSTN === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done act_id=%0d exp=none @%0t", done_id, $time);
      end else begin
        e = sb_q.pop_front();
        check("done_id", 32'(done_id), 32'(e.id));
        check("tmo", 32'(tmo), 32'(e.tmo));
        check("meas_cyc", 32'(meas_cyc), 32'(e.meas));
        check("grant_at_done", 32'(grant), 32'd0);
        check("dly_i_at_done", 32'(dly_i), 32'd0);
      end
    end
  end

  task automatic do_reset();
    CELRSTN = 1'b0;
    req     = '0;
    mode    = M_NORM;
    dsel    = 1;
    repeat (3) @(negedge CELCLK);
    CELRSTN = 1'b1;
    @(negedge CELCLK);
  endtask

  // Wait for done, then for busy to fall; both bounded
  task automatic finish_txn(input string nm);
    bit got;
    int k;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge CELCLK);
      if (done) got = 1'b1;
    end
    check({nm, "_done_seen"}, 32'(got), 32'd1);
    k = 0;
    while (busy && k < 60) begin
      @(negedge CELCLK);
      k++;
    end
    check({nm, "_busy_low"}, 32'(busy), 32'd0);
    repeat (2) @(negedge CELCLK);
    check({nm, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int  hi;
    int  k;
    bit  got;
    bit  stable;
    mode = v.mode;
    dsel = v.d;
    req  = v.req;
    @(negedge CELCLK);
    check($sformatf("v%0d_grant_lat", n), 32'(grant), 32'(v.grant));
    check($sformatf("v%0d_dly_i_lat", n), 32'(dly_i), 32'd1);
    push_exp(v.id, v.tmo, v.meas);
    req    = '0;
    hi     = 1;
    got    = 1'b0;
    stable = 1'b1;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge CELCLK);
      if (done) got = 1'b1;
      else begin
        if (dly_i) hi++;
        if (grant !== v.grant) stable = 1'b0;
      end
    end
    check($sformatf("v%0d_done_seen", n), 32'(got), 32'd1);
    check($sformatf("v%0d_fire_cycles", n), 32'(hi), 32'(v.hi));
    check($sformatf("v%0d_grant_stable", n), 32'(stable), 32'd1);
    k = 0;
    while (busy && k < 60) begin
      @(negedge CELCLK);
      k++;
    end
    checks++;
    if (k < RECOV_CYC || k > RECOV_CYC + 1) begin
      errors++;
      $display("FAIL v%0d_busy_drop act=%0d exp=%0d..%0d", n, k, RECOV_CYC, RECOV_CYC + 1);
    end
    mode = M_NORM;
    repeat (3) @(negedge CELCLK);
    check($sformatf("v%0d_idle_grant", n), 32'(grant), 32'd0);
    check($sformatf("v%0d_idle_busy", n), 32'(busy), 32'd0);
    check($sformatf("v%0d_sb_empty", n), 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] eg;
    logic       prev;
    int         nl;
    int         cyc;
    int         last;

    //         req      mode     d  grant    id    tmo   meas   hi
    vecs[0] = '{4'b0100, M_NORM,  1, 4'b0100, 3'd2, 1'b0, 8'd3,  4};
    vecs[1] = '{4'b0001, M_NORM,  2, 4'b0001, 3'd0, 1'b0, 8'd4,  5};
    vecs[2] = '{4'b1001, M_NORM,  1, 4'b1000, 3'd3, 1'b0, 8'd3,  4};
    vecs[3] = '{4'b1001, M_NORM,  3, 4'b0001, 3'd0, 1'b0, 8'd5,  6};
    vecs[4] = '{4'b0010, M_DEAD,  1, 4'b0010, 3'd1, 1'b1, 8'hFF, TOUT_CYC};
    vecs[5] = '{4'b0011, M_STUCK, 1, 4'b0001, 3'd0, 1'b1, 8'd3,  4};
    vecs[6] = '{4'b0011, M_NORM,  1, 4'b0010, 3'd1, 1'b0, 8'd3,  4};
    vecs[7] = '{4'b1110, M_NORM,  4, 4'b0100, 3'd2, 1'b0, 8'd6,  7};

    do_reset();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_dly_i", 32'(dly_i), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_tmo", 32'(tmo), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_meas", 32'(meas_cyc), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset in the second FIRE cycle, then req[1] alone is served first
    do_reset();
    req = 4'b0100;
    @(negedge CELCLK);
    check("mid_grant", 32'(grant), 32'b0100);
    @(posedge CELCLK);
    #2;
    CELRSTN = 1'b0;
    req     = 4'b0010;
    #1;
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_dly_i", 32'(dly_i), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_done_id", 32'(done_id), 32'd0);
    check("mid_rst_tmo", 32'(tmo), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_meas", 32'(meas_cyc), 32'd0);
    repeat (2) @(negedge CELCLK);
    CELRSTN = 1'b1;
    @(negedge CELCLK);
    check("post_rst_grant", 32'(grant), 32'b0010);
    check("post_rst_dly_i", 32'(dly_i), 32'd1);
    push_exp(3'd1, 1'b0, 8'd3);
    req = '0;
    finish_txn("post_rst");

    // Continuous requests: grants rotate 0,1,2,3,0 with a bounded minimum spacing
    do_reset();
    req  = 4'b1111;
    prev = 1'b0;
    nl   = 0;
    cyc  = 0;
    last = 0;
    for (int c = 0; c < 600 && nl < 5; c++) begin
      @(negedge CELCLK);
      cyc++;
      if (dly_i && !prev) begin
        eg = 4'b0001 << (nl % 4);
        check($sformatf("rr%0d_grant", nl), 32'(grant), 32'(eg));
        if (nl > 0) begin
          checks++;
          if (cyc - last < int'(RECOV_CYC) + 3) begin
            errors++;
            $display("FAIL rr%0d_spacing act=%0d exp>=%0d", nl, cyc - last, RECOV_CYC + 3);
          end
        end
        push_exp(3'(nl % 4), 1'b0, 8'd3);
        nl++;
        last = cyc;
        if (nl == 5) req = '0;
      end
      prev = dly_i;
    end
    check("rr_launches", 32'(nl), 32'd5);
    finish_txn("rr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
